sig_l_serializer: RTL and testbench

Downstream consumer of the `sub2` output group `sig_l` (three 8-bit elements, unpacked `[7:0] [3]`). It accepts one whole group per handshake and emits its bytes one per beat on a byte-wide valid/ready stream. Optionally it appends a modular checksum beat. It sits between `top`'s AUTOOUTPUT `sig_l` and the byte-serial link logic, and decouples the parallel group from the downstream rate.

---
 rtl/sig_l_serializer.sv | 150 +++++++++++++++
 tb/tb_sig_l_serializer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_l_serializer.sv
// sig_l_serializer: takes one parallel sig_l group per handshake and streams
// its elements out one byte per beat, optionally followed by a modular
// checksum beat. Counts completed groups.
module sig_l_serializer #(
  parameter int BYTE_W     = 8,
  parameter int NUM_BYTES  = 3,
  parameter int APPEND_SUM = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] sig_l [NUM_BYTES],
  input  logic              l_valid,
  output logic              l_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [3:0]        out_idx,
  output logic [CNT_W-1:0]  grp_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_SUM
  } state_t;

  localparam logic [3:0]       LAST_DATA_IDX = 4'(NUM_BYTES - 1);
  localparam bit               HAS_SUM       = (APPEND_SUM != 0);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  state_t              r_state;
  logic [BYTE_W-1:0]   r_hold [NUM_BYTES];
  logic [BYTE_W-1:0]   r_acc;
  logic [3:0]          r_idx;
  logic [BYTE_W-1:0]   r_data;
  logic                r_valid;
  logic                r_last;
  logic [CNT_W-1:0]    r_cnt;

  state_t              w_stateNext;
  logic [BYTE_W-1:0]   w_accNext;
  logic [3:0]          w_idxNext;
  logic [BYTE_W-1:0]   w_dataNext;
  logic                w_validNext;
  logic                w_lastNext;
  logic [CNT_W-1:0]    w_cntNext;
  logic [BYTE_W-1:0]   w_curByte;
  logic [BYTE_W-1:0]   w_nextByte;
  logic [BYTE_W-1:0]   w_beatSum;
  logic                w_fire;
  logic                w_done;
  logic                w_capture;

  // A beat handshakes when the registered valid meets downstream ready; the
  // group completes on the handshake of the beat flagged as last.
  assign w_fire    = r_valid & out_ready;
  assign w_done    = w_fire & r_last;
  assign l_ready   = (r_state == ST_IDLE) | w_done;
  assign w_capture = l_valid & l_ready;
  assign w_beatSum = r_acc + w_curByte;

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign out_idx   = r_idx;
  assign grp_cnt   = r_cnt;

  // Select the held byte for the current beat and the one after it.
  always_comb begin
    w_curByte  = '0;
    w_nextByte = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (r_idx == 4'(i)) w_curByte = r_hold[i];
      if ((r_idx + 4'd1) == 4'(i)) w_nextByte = r_hold[i];
    end
  end

  // Next-state and next-output logic; capture overrides completion so a
  // waiting group follows the last beat without a bubble.
  always_comb begin
    w_stateNext = r_state;
    w_accNext   = r_acc;
    w_idxNext   = r_idx;
    w_dataNext  = r_data;
    w_validNext = r_valid;
    w_lastNext  = r_last;
    w_cntNext   = r_cnt;

    if (w_fire && (r_state == ST_DATA)) begin
      w_accNext = w_beatSum;
      w_idxNext = r_idx + 4'd1;
      if (r_idx == LAST_DATA_IDX) begin
        if (HAS_SUM) begin
          w_stateNext = ST_SUM;
          w_dataNext  = w_beatSum;
          w_lastNext  = 1'b1;
        end
      end else begin
        w_dataNext = w_nextByte;
        w_lastNext = !HAS_SUM && ((r_idx + 4'd1) == LAST_DATA_IDX);
      end
    end

    if (w_done) begin
      w_cntNext   = r_cnt + CNT_ONE;
      w_stateNext = ST_IDLE;
      w_validNext = 1'b0;
      w_lastNext  = 1'b0;
      w_idxNext   = '0;
    end

    if (w_capture) begin
      w_stateNext = ST_DATA;
      w_accNext   = '0;
      w_idxNext   = '0;
      w_dataNext  = sig_l[0];
      w_validNext = 1'b1;
      w_lastNext  = 1'b0;
    end
  end

  // State and registered outputs; reset discards any group in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_acc   <= w_accNext;
      r_idx   <= w_idxNext;
      r_data  <= w_dataNext;
      r_valid <= w_validNext;
      r_last  <= w_lastNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Hold register samples the parallel group only at capture.
  always_ff @(posedge clk) begin
    if (w_capture) r_hold <= sig_l;
  end

endmodule

// File: tb/tb_sig_l_serializer.sv
// tb_sig_l_serializer: scoreboard bench for sig_l_serializer with a default
// instance, a no-checksum instance and a 2-bit group counter instance.
module tb_sig_l_serializer;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] idx;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  sigL [3];
  logic        lValid = 1'b0;
  logic        outReady = 1'b0;
  logic        lReady;
  logic [7:0]  outData;
  logic        outValid;
  logic        outLast;
  logic [3:0]  outIdx;
  logic [15:0] grpCnt;

  logic [7:0]  nsSigL [3];
  logic        nsLValid = 1'b0;
  logic        nsOutReady = 1'b0;
  logic        nsLReady;
  logic [7:0]  nsOutData;
  logic        nsOutValid;
  logic        nsOutLast;
  logic [3:0]  nsOutIdx;
  logic [15:0] nsGrpCnt;

  logic        wrLReady;
  logic [7:0]  wrOutData;
  logic        wrOutValid;
  logic        wrOutLast;
  logic [3:0]  wrOutIdx;
  logic [1:0]  wrGrpCnt;

  beat_t expQ[$];
  beat_t nsQ[$];
  beat_t monE;
  beat_t nsE;
  int    total = 0;
  int    bad = 0;
  int    expCnt = 0;

  sig_l_serializer u_dut (
    .clk(clk), .rst_n(rst_n), .sig_l(sigL), .l_valid(lValid), .l_ready(lReady),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady),
    .out_last(outLast), .out_idx(outIdx), .grp_cnt(grpCnt)
  );

  sig_l_serializer #(.APPEND_SUM(0)) u_nosum (
    .clk(clk), .rst_n(rst_n), .sig_l(nsSigL), .l_valid(nsLValid), .l_ready(nsLReady),
    .out_data(nsOutData), .out_valid(nsOutValid), .out_ready(nsOutReady),
    .out_last(nsOutLast), .out_idx(nsOutIdx), .grp_cnt(nsGrpCnt)
  );

  sig_l_serializer #(.CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .sig_l(sigL), .l_valid(lValid), .l_ready(wrLReady),
    .out_data(wrOutData), .out_valid(wrOutValid), .out_ready(outReady),
    .out_last(wrOutLast), .out_idx(wrOutIdx), .grp_cnt(wrGrpCnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted beat is compared against the next expected beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (outValid && outReady) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL beat_unexpected got data=%02h idx=%0d required no beat", outData, outIdx);
        end else begin
          monE = expQ.pop_front();
          if ({outData, outIdx, outLast} !== monE) begin
            bad++;
            $display("[TB] FAIL beat got data=%02h idx=%0d last=%b required data=%02h idx=%0d last=%b",
                     outData, outIdx, outLast, monE.data, monE.idx, monE.last);
          end
        end
      end
      if (nsOutValid && nsOutReady) begin
        total++;
        if (nsQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL ns_beat_unexpected got data=%02h idx=%0d required no beat", nsOutData, nsOutIdx);
        end else begin
          nsE = nsQ.pop_front();
          if ({nsOutData, nsOutIdx, nsOutLast} !== nsE) begin
            bad++;
            $display("[TB] FAIL ns_beat got data=%02h idx=%0d last=%b required data=%02h idx=%0d last=%b",
                     nsOutData, nsOutIdx, nsOutLast, nsE.data, nsE.idx, nsE.last);
          end
        end
      end
    end
  end

  // Present a group on the default instance, push its expected beats and
  // wait for capture; returns just after the capturing edge.
  task automatic offerGroup(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input bit keepValid);
    logic [7:0] s;
    bit got;
    s = a + b + c;
    sigL[0] = a;
    sigL[1] = b;
    sigL[2] = c;
    expQ.push_back({a, 4'd0, 1'b0});
    expQ.push_back({b, 4'd1, 1'b0});
    expQ.push_back({c, 4'd2, 1'b0});
    expQ.push_back({s, 4'd3, 1'b1});
    lValid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (lReady) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL capture_timeout l_ready=%b required 1", lReady);
    end else begin
      @(posedge clk);
      #1;
    end
    if (!keepValid) lValid = 1'b0;
  endtask

  // Wait (bounded) until every expected beat has been seen, then step past
  // the completing edge.
  task automatic waitDrain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (expQ.size() == 0 && nsQ.size() == 0) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL drain_timeout pending=%0d ns_pending=%0d required 0", expQ.size(), nsQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total += 6;
    if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid got %b required 0", outValid); end
    if (outLast !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_last got %b required 0", outLast); end
    if (outData !== 8'h00) begin bad++; $display("[TB] FAIL rst_out_data got %02h required 00", outData); end
    if (outIdx !== 4'd0) begin bad++; $display("[TB] FAIL rst_out_idx got %0d required 0", outIdx); end
    if (grpCnt !== 16'd0) begin bad++; $display("[TB] FAIL rst_grp_cnt got %0d required 0", grpCnt); end
    if (lReady !== 1'b1) begin bad++; $display("[TB] FAIL rst_l_ready got %b required 1", lReady); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_counter_wrap();
    int wrapSeq [5];
    wrapSeq = '{1, 2, 3, 0, 1};
    outReady = 1'b1;
    for (int g = 0; g < 5; g++) begin
      offerGroup(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      waitDrain();
      expCnt++;
      total += 2;
      if (wrGrpCnt !== 2'(wrapSeq[g])) begin
        bad++;
        $display("[TB] FAIL wrap_cnt group=%0d got %0d required %0d", g, wrGrpCnt, wrapSeq[g]);
      end
      if (grpCnt !== 16'(expCnt)) begin
        bad++;
        $display("[TB] FAIL wrap_main_cnt got %0d required %0d", grpCnt, expCnt);
      end
    end
  endtask

  task automatic test_basic();
    outReady = 1'b1;
    offerGroup(8'h11, 8'h22, 8'h33, 1'b0);
    waitDrain();
    expCnt++;
    total++;
    if (grpCnt !== 16'(expCnt)) begin
      bad++;
      $display("[TB] FAIL basic_cnt got %0d required %0d", grpCnt, expCnt);
    end
  endtask

  task automatic test_checksum_wrap();
    outReady = 1'b1;
    offerGroup(8'hFF, 8'hFF, 8'h03, 1'b0);
    waitDrain();
    expCnt++;
    total++;
    if (grpCnt !== 16'(expCnt)) begin
      bad++;
      $display("[TB] FAIL sumwrap_cnt got %0d required %0d", grpCnt, expCnt);
    end
    nsOutReady = 1'b1;
    nsSigL[0] = 8'hAA;
    nsSigL[1] = 8'hBB;
    nsSigL[2] = 8'hCC;
    nsQ.push_back({8'hAA, 4'd0, 1'b0});
    nsQ.push_back({8'hBB, 4'd1, 1'b0});
    nsQ.push_back({8'hCC, 4'd2, 1'b1});
    nsLValid = 1'b1;
    @(posedge clk);
    #1;
    nsLValid = 1'b0;
    waitDrain();
    total++;
    if (nsGrpCnt !== 16'd1) begin
      bad++;
      $display("[TB] FAIL nosum_cnt got %0d required 1", nsGrpCnt);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (nsOutValid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL nosum_extra_beat got valid=%b required 0", nsOutValid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    outReady = 1'b0;
    offerGroup(8'h11, 8'h22, 8'h33, 1'b0);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total += 4;
      if (outData !== 8'h22) begin bad++; $display("[TB] FAIL bp_data got %02h required 22", outData); end
      if (outIdx !== 4'd1) begin bad++; $display("[TB] FAIL bp_idx got %0d required 1", outIdx); end
      if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid got %b required 1", outValid); end
      if (lReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_l_ready got %b required 0", lReady); end
      sigL[0] = 8'($urandom);
      sigL[1] = 8'($urandom);
      sigL[2] = 8'($urandom);
    end
    @(posedge clk);
    #1;
    outReady = 1'b1;
    waitDrain();
    expCnt++;
    total++;
    if (grpCnt !== 16'(expCnt)) begin
      bad++;
      $display("[TB] FAIL bp_cnt got %0d required %0d", grpCnt, expCnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s2;
    outReady = 1'b1;
    offerGroup(8'h01, 8'h02, 8'h03, 1'b1);
    sigL[0] = 8'h10;
    sigL[1] = 8'h20;
    sigL[2] = 8'h30;
    s2 = 8'h60;
    expQ.push_back({8'h10, 4'd0, 1'b0});
    expQ.push_back({8'h20, 4'd1, 1'b0});
    expQ.push_back({8'h30, 4'd2, 1'b0});
    expQ.push_back({s2, 4'd3, 1'b1});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total += 2;
      if (outValid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_valid beat=%0d got %b required 1", i, outValid);
      end
      if (lReady !== ((i == 3) || (i == 7))) begin
        bad++;
        $display("[TB] FAIL b2b_l_ready beat=%0d got %b required %b", i, lReady, (i == 3) || (i == 7));
      end
      if (i == 3) begin
        @(posedge clk);
        #1;
        lValid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    expCnt += 2;
    total += 2;
    if (grpCnt !== 16'(expCnt)) begin
      bad++;
      $display("[TB] FAIL b2b_cnt got %0d required %0d", grpCnt, expCnt);
    end
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL b2b_pending got %0d required 0", expQ.size());
    end
  endtask

  task automatic test_reset_mid_group();
    outReady = 1'b0;
    offerGroup(8'h41, 8'h42, 8'h43, 1'b0);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    rst_n = 1'b0;
    #1;
    total += 3;
    if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid got %b required 0", outValid); end
    if (grpCnt !== 16'd0) begin bad++; $display("[TB] FAIL midrst_cnt got %0d required 0", grpCnt); end
    if (lReady !== 1'b1) begin bad++; $display("[TB] FAIL midrst_l_ready got %b required 1", lReady); end
    expQ.delete();
    nsQ.delete();
    expCnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    outReady = 1'b1;
    offerGroup(8'h05, 8'h06, 8'h07, 1'b0);
    waitDrain();
    expCnt++;
    total++;
    if (grpCnt !== 16'(expCnt)) begin
      bad++;
      $display("[TB] FAIL midrst_new_cnt got %0d required %0d", grpCnt, expCnt);
    end
  endtask

  // Overall time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout reached required completion");
    $fatal(1, "[TB] timeout");
  end

  // Test sequence.
  initial begin
    foreach (sigL[i]) sigL[i] = 8'h00;
    foreach (nsSigL[i]) nsSigL[i] = 8'h00;
    $display("[TB] start");
    test_reset();
    test_counter_wrap();
    test_basic();
    test_checksum_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_group();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
